// File: rtl/strand_fetch_buffer_if.sv
// Instruction-cache request/response bundle for the strand fetch buffer.
// The master side issues fetches and receives returned words.
`ifndef STRANDS_PER_CORE
`define STRANDS_PER_CORE 4
`endif
`ifndef STRAND_INDEX_WIDTH
`define STRAND_INDEX_WIDTH 2
`endif
`ifndef NOP
`define NOP 32'h0000_0000
`endif

interface strand_fetch_buffer_if;
   logic                           ifetch_request;
   logic [31:0]                    ifetch_pc;
   logic [`STRAND_INDEX_WIDTH-1:0] ifetch_strand;
   logic                           icache_data_valid;
   logic [31:0]                    icache_data;
   logic [`STRAND_INDEX_WIDTH-1:0] icache_strand;

   modport master (
      output ifetch_request,
      output ifetch_pc,
      output ifetch_strand,
      input  icache_data_valid,
      input  icache_data,
      input  icache_strand
   );

   modport slave (
      input  ifetch_request,
      input  ifetch_pc,
      input  ifetch_strand,
      output icache_data_valid,
      output icache_data,
      output icache_strand
   );
endinterface

// File: rtl/strand_fetch_buffer.sv
// Per-strand two-entry instruction buffer with round-robin fetch.
// One fetch is outstanding core-wide; rollback flushes and redirects.
`ifndef STRANDS_PER_CORE
`define STRANDS_PER_CORE 4
`endif
`ifndef STRAND_INDEX_WIDTH
`define STRAND_INDEX_WIDTH 2
`endif
`ifndef NOP
`define NOP 32'h0000_0000
`endif

module strand_fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [`STRANDS_PER_CORE-1:0]     cr_strand_enable,
   strand_fetch_buffer_if.master            ic,
   input  logic [`STRANDS_PER_CORE-1:0]     rb_rollback_strand,
   input  logic [`STRANDS_PER_CORE*32-1:0]  rb_rollback_pc,
   input  logic [`STRANDS_PER_CORE-1:0]     ss_instruction_req,
   output logic [`STRANDS_PER_CORE-1:0]     if_instruction_valid,
   output logic [`STRANDS_PER_CORE*32-1:0]  if_instruction,
   output logic [`STRANDS_PER_CORE*32-1:0]  if_pc,
   output logic [`STRANDS_PER_CORE-1:0]     if_branch_predicted,
   output logic [`STRANDS_PER_CORE-1:0]     if_long_latency
);
   localparam int NS = `STRANDS_PER_CORE;
   localparam int IW = `STRAND_INDEX_WIDTH;

   logic [31:0]   fpc_q [NS];
   logic [31:0]   fpc_d [NS];
   logic [1:0]    cnt_q [NS];
   logic [1:0]    cnt_d [NS];
   logic [31:0]   epc_q [NS][2];
   logic [31:0]   epc_d [NS][2];
   logic [31:0]   ein_q [NS][2];
   logic [31:0]   ein_d [NS][2];
   logic [NS-1:0] pend_q, pend_d;
   logic [NS-1:0] drop_q, drop_d;
   logic [31:0]   rpc_q, rpc_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic [NS-1:0] elig;
   logic          gnt_v;
   logic [IW-1:0] gnt_s;
   logic [IW-1:0] scan;
   logic [NS-1:0] pop_v, rsp_v, push_v;
   logic [1:0]    lvl [NS];

   // Pick one eligible strand, searching from the one after the last grant
   always_comb begin
      elig  = '0;
      gnt_v = 1'b0;
      gnt_s = '0;
      scan  = '0;
      for (int s = 0; s < NS; s++) begin
         elig[s] = cr_strand_enable[s] & ~pend_q[s]
                 & (cnt_q[s] != 2'd2);
      end
      if (pend_q != '0) begin
         elig = '0;
      end
      for (int i = 0; i < NS; i++) begin
         scan = ptr_q + IW'(i);
         if (!gnt_v && elig[scan]) begin
            gnt_v = 1'b1;
            gnt_s = scan;
         end
      end
   end

   assign ic.ifetch_request = gnt_v & reset_n;
   assign ic.ifetch_pc      = fpc_q[gnt_s];
   assign ic.ifetch_strand  = gnt_s;

   // Next state: grant bookkeeping, response push, head pop, rollback
   always_comb begin
      ptr_d = gnt_v ? gnt_s + IW'(1) : ptr_q;
      rpc_d = gnt_v ? fpc_q[gnt_s] : rpc_q;
      pend_d = pend_q;
      drop_d = drop_q;
      pop_v  = '0;
      rsp_v  = '0;
      push_v = '0;
      for (int s = 0; s < NS; s++) begin
         fpc_d[s] = fpc_q[s];
         cnt_d[s] = cnt_q[s];
         epc_d[s] = epc_q[s];
         ein_d[s] = ein_q[s];
         pop_v[s] = ss_instruction_req[s] & (cnt_q[s] != 2'd0);
         rsp_v[s] = ic.icache_data_valid & pend_q[s]
                  & (ic.icache_strand == IW'(s));
         lvl[s]   = cnt_q[s] - {1'b0, pop_v[s]};
         push_v[s] = rsp_v[s] & ~drop_q[s] & (lvl[s] != 2'd2);
         if (gnt_v && gnt_s == IW'(s)) begin
            pend_d[s] = 1'b1;
            fpc_d[s]  = fpc_q[s] + 32'd4;
         end
         if (rsp_v[s]) begin
            pend_d[s] = 1'b0;
            drop_d[s] = 1'b0;
         end
         if (rb_rollback_strand[s]) begin
            cnt_d[s]  = 2'd0;
            fpc_d[s]  = rb_rollback_pc[s*32 +: 32];
            drop_d[s] = pend_d[s];
         end else begin
            if (pop_v[s]) begin
               epc_d[s][0] = epc_q[s][1];
               ein_d[s][0] = ein_q[s][1];
            end
            if (push_v[s]) begin
               epc_d[s][lvl[s][0]] = rpc_q;
               ein_d[s][lvl[s][0]] = ic.icache_data;
            end
            cnt_d[s] = lvl[s] + {1'b0, push_v[s]};
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         drop_q <= '0;
         rpc_q  <= '0;
         ptr_q  <= '0;
         for (int s = 0; s < NS; s++) begin
            fpc_q[s]    <= RESET_PC;
            cnt_q[s]    <= 2'd0;
            epc_q[s][0] <= '0;
            epc_q[s][1] <= '0;
            ein_q[s][0] <= '0;
            ein_q[s][1] <= '0;
         end
      end else begin
         pend_q <= pend_d;
         drop_q <= drop_d;
         rpc_q  <= rpc_d;
         ptr_q  <= ptr_d;
         for (int s = 0; s < NS; s++) begin
            fpc_q[s] <= fpc_d[s];
            cnt_q[s] <= cnt_d[s];
            epc_q[s] <= epc_d[s];
            ein_q[s] <= ein_d[s];
         end
      end
   end

   // Head presentation and static decode per strand
   always_comb begin
      if_instruction_valid = '0;
      if_instruction       = '0;
      if_pc                = '0;
      if_branch_predicted  = '0;
      if_long_latency      = '0;
      for (int s = 0; s < NS; s++) begin
         if_instruction[s*32 +: 32] = `NOP;
         if (cnt_q[s] != 2'd0) begin
            if_instruction_valid[s]    = 1'b1;
            if_instruction[s*32 +: 32] = ein_q[s][0];
            if_pc[s*32 +: 32]          = epc_q[s][0];
            if_long_latency[s] =
               (ein_q[s][0][31:28] == 4'b1100);
            if_branch_predicted[s] =
               (ein_q[s][0][31:28] == 4'b1111)
               & ein_q[s][0][24];
         end
      end
   end
endmodule

// File: tb/tb_strand_fetch_buffer.sv
// Bench for strand_fetch_buffer: directed scenarios then random traffic
// compared against a queue-based reference model.
`ifndef NOP
`define NOP 32'h0000_0000
`endif

module tb_strand_fetch_buffer;
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    en = '0;
   logic [3:0]    rb = '0;
   logic [127:0]  rbpc = '0;
   logic [3:0]    pop = '0;
   logic [3:0]    o_valid, o_bp, o_ll;
   logic [127:0]  o_ins, o_pc;

   strand_fetch_buffer_if ifc ();

   strand_fetch_buffer #(.RESET_PC(32'h0)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .cr_strand_enable     (en),
      .ic                   (ifc),
      .rb_rollback_strand   (rb),
      .rb_rollback_pc       (rbpc),
      .ss_instruction_req   (pop),
      .if_instruction_valid (o_valid),
      .if_instruction       (o_ins),
      .if_pc                (o_pc),
      .if_branch_predicted  (o_bp),
      .if_long_latency      (o_ll)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq [4][$];
   logic [31:0] mfpc [4];
   bit          mpend [4];
   bit          mdrop [4];
   int          mptr;
   logic [31:0] mreqpc;

   int checks = 0;
   int errors = 0;

   logic        obs_req;
   logic [31:0] obs_pc;
   logic [1:0]  obs_strand;
   logic [3:0]  obs_valid;
   logic [127:0] obs_pcv;
   logic [3:0]  obs_bp, obs_ll;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         mq[s].delete();
         mfpc[s]  = 32'h0;
         mpend[s] = 0;
         mdrop[s] = 0;
      end
      mptr   = 0;
      mreqpc = 32'h0;
   endtask

   function automatic int mgrant(input logic [3:0] e);
      int r;
      r = -1;
      for (int s = 0; s < 4; s++) if (mpend[s]) return -1;
      for (int i = 0; i < 4; i++) begin
         if (r < 0 && e[(mptr + i) % 4] && mq[(mptr + i) % 4].size() < 2)
            r = (mptr + i) % 4;
      end
      return r;
   endfunction

   task automatic check_outs(input bit in_rst, output int g);
      logic [3:0]   ev, ebp, ell;
      logic [127:0] eins, epc;
      logic [31:0]  w;
      g = in_rst ? -1 : mgrant(en);
      ev = '0; ebp = '0; ell = '0; eins = '0; epc = '0;
      for (int s = 0; s < 4; s++) begin
         eins[s*32 +: 32] = `NOP;
         if (mq[s].size() > 0) begin
            w = mq[s][0].ins;
            ev[s] = 1'b1;
            eins[s*32 +: 32] = w;
            epc[s*32 +: 32]  = mq[s][0].pc;
            ell[s] = (w[31:28] == 4'hC);
            ebp[s] = (w[31:28] == 4'hF) && w[24];
         end
      end
      chk("ifetch_request", ifc.ifetch_request, g >= 0);
      if (g >= 0) begin
         chk("ifetch_pc", ifc.ifetch_pc, mfpc[g]);
         chk("ifetch_strand", ifc.ifetch_strand, g[1:0]);
      end
      chk("if_valid", o_valid, ev);
      chk("if_instruction", o_ins, eins);
      chk("if_pc", o_pc, epc);
      chk("if_bp", o_bp, ebp);
      chk("if_ll", o_ll, ell);
      obs_req = ifc.ifetch_request;
      obs_pc = ifc.ifetch_pc;
      obs_strand = ifc.ifetch_strand;
      obs_valid = o_valid;
      obs_pcv = o_pc;
      obs_bp = o_bp;
      obs_ll = o_ll;
   endtask

   // One clock: drive at the falling edge, check, then apply the model
   task automatic cyc(input logic [3:0] e, input logic [3:0] p,
                      input logic [3:0] r, input logic [127:0] rp,
                      input logic rv, input logic [31:0] rd,
                      input logic [1:0] rs);
      int g;
      bit popok [4];
      bit pushit;
      logic [31:0] pushpc;
      en = e; pop = p; rb = r; rbpc = rp;
      ifc.icache_data_valid = rv;
      ifc.icache_data = rd;
      ifc.icache_strand = rs;
      #1;
      check_outs(0, g);
      @(posedge clk);
      for (int s = 0; s < 4; s++) popok[s] = p[s] && mq[s].size() > 0;
      pushpc = mreqpc;
      pushit = 0;
      if (rv && mpend[rs]) begin
         mpend[rs] = 0;
         pushit = !mdrop[rs];
         mdrop[rs] = 0;
      end
      if (g >= 0) begin
         mpend[g] = 1;
         mreqpc = mfpc[g];
         mfpc[g] = mfpc[g] + 32'd4;
         mptr = (g + 1) % 4;
      end
      for (int s = 0; s < 4; s++) begin
         if (r[s]) begin
            mq[s].delete();
            mfpc[s] = rp[s*32 +: 32];
            mdrop[s] = mpend[s];
         end else begin
            if (popok[s]) void'(mq[s].pop_front());
            if (pushit && rs == s[1:0]) mq[s].push_back({pushpc, rd});
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_cyc(input logic [3:0] e);
      cyc(e, 4'h0, 4'h0, '0, 1'b0, 32'h0, 2'd0);
   endtask

   task automatic resp(input logic [3:0] e, input logic [3:0] p,
                       input logic [1:0] s, input logic [31:0] d);
      cyc(e, p, 4'h0, '0, 1'b1, d, s);
   endtask

   task automatic do_reset(input logic [3:0] e);
      int g;
      en = e; pop = '0; rb = '0; rbpc = '0;
      ifc.icache_data_valid = 1'b0;
      ifc.icache_data = '0;
      ifc.icache_strand = '0;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outs(1, g);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int gl [$];
      int ps;
      logic [3:0] re, rr;
      logic [127:0] rpv;
      logic rv;
      logic [1:0] rs;
      logic [127:0] nopv;

      // Basic fetch, response and head presentation
      do_reset(4'b0001);
      idle_cyc(4'b0001);
      chk("r036_req", obs_req, 1);
      chk("r036_pc", obs_pc, 32'h0);
      resp(4'b0001, 4'h0, 2'd0, 32'h1234_5678);
      idle_cyc(4'b0001);
      chk("r036_valid", obs_valid[0], 1);
      chk("r036_ifpc", obs_pcv[31:0], 32'h0);
      chk("r037_pc4", obs_pc, 32'h4);
      resp(4'b0001, 4'h0, 2'd0, 32'hF100_0000);
      idle_cyc(4'b0001);
      chk("r037_full", obs_req, 0);
      cyc(4'b0001, 4'b0001, 4'h0, '0, 1'b0, 32'h0, 2'd0);
      idle_cyc(4'b0001);
      chk("r037_pc8", obs_pc, 32'h8);
      chk("r040_bp", obs_bp[0], 1);
      resp(4'b0001, 4'h0, 2'd0, 32'hC000_0000);
      cyc(4'b0001, 4'b0001, 4'h0, '0, 1'b0, 32'h0, 2'd0);
      idle_cyc(4'b0000);
      chk("r040_ll", obs_ll[0], 1);
      chk("r034_noreq", obs_req, 0);
      chk("r034_vis", obs_valid[0], 1);

      // Round-robin order across all strands
      do_reset(4'b1111);
      for (int i = 0; i < 12; i++) begin
         ps = -1;
         for (int s = 0; s < 4; s++) if (mpend[s]) ps = s;
         cyc(4'b1111, 4'b1111, 4'h0, '0, ps >= 0,
             $urandom, ps[1:0]);
         if (obs_req) gl.push_back(int'(obs_strand));
      end
      chk("r038_n", gl.size(), 6);
      chk("r038_g0", gl[0], 0);
      chk("r038_g1", gl[1], 1);
      chk("r038_g2", gl[2], 2);
      chk("r038_g3", gl[3], 3);
      chk("r038_g4", gl[4], 0);

      // Rollback with a request outstanding
      do_reset(4'b0010);
      idle_cyc(4'b0010);
      chk("r039_first", obs_strand, 2'd1);
      rpv = '0;
      rpv[63:32] = 32'h100;
      cyc(4'b0010, 4'h0, 4'b0010, rpv, 1'b0, 32'h0, 2'd0);
      resp(4'b0010, 4'h0, 2'd1, 32'hDEAD_BEEF);
      idle_cyc(4'b0010);
      chk("r039_drop", obs_valid[1], 0);
      chk("r039_pc", obs_pc, 32'h100);
      chk("r039_req", obs_req, 1);

      // Reset asserted while a response is on the bus
      do_reset(4'b0001);
      idle_cyc(4'b0001);
      resp(4'b0001, 4'h0, 2'd0, 32'hAAAA_5555);
      idle_cyc(4'b0001);
      ifc.icache_data_valid = 1'b1;
      ifc.icache_data = 32'h5555_AAAA;
      ifc.icache_strand = 2'd0;
      #2;
      reset_n = 1'b0;
      #1;
      nopv = {4{`NOP}};
      chk("r041_req", ifc.ifetch_request, 0);
      chk("r041_valid", o_valid, 4'h0);
      chk("r041_pc", o_pc, '0);
      chk("r041_ins", o_ins, nopv);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      ifc.icache_data_valid = 1'b0;
      reset_n = 1'b1;
      idle_cyc(4'b0000);
      chk("r041_nopush", obs_valid, 4'h0);

      // Random traffic against the model
      do_reset(4'($urandom));
      for (int i = 0; i < 600; i++) begin
         re = 4'($urandom);
         rr = 4'h0;
         rpv = '0;
         if ($urandom_range(15) == 0) rr[$urandom_range(3)] = 1'b1;
         for (int s = 0; s < 4; s++)
            rpv[s*32 +: 32] = {$urandom_range(255), 2'b00};
         ps = -1;
         for (int s = 0; s < 4; s++) if (mpend[s]) ps = s;
         rv = 1'b0;
         rs = 2'd0;
         if (ps >= 0 && $urandom_range(2) == 0) begin
            rv = 1'b1;
            rs = ps[1:0];
         end else if (ps < 0 && $urandom_range(9) == 0) begin
            rv = 1'b1;
            rs = 2'($urandom);
         end
         cyc(re, 4'($urandom), rr, rpv, rv, $urandom, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/strand_fetch_buffer.md
STRAND_FETCH_BUFFER -- requirements
Module: strand_fetch_buffer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, giving the fetch PC loaded into every strand at reset.
REQ-002 The block SHALL have clk  input  1  as its single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have reset_n  input  1  as its reset, which is asynchronous and active-low.
REQ-004 The block SHALL have cr_strand_enable  input  `STRANDS_PER_CORE  as the per-strand fetch enable.
REQ-005 The block SHALL have ifetch_request  output  1  as the instruction-cache request strobe.
REQ-006 The block SHALL have ifetch_pc  output  32  as the request address.
REQ-007 The block SHALL have ifetch_strand  output  `STRAND_INDEX_WIDTH  as the requesting strand.
REQ-008 The block SHALL have icache_data_valid  input  1  as the response strobe.
REQ-009 The block SHALL have icache_data  input  32  as the returned instruction word.
REQ-010 The block SHALL have icache_strand  input  `STRAND_INDEX_WIDTH  as the response strand.
REQ-011 The block SHALL have rb_rollback_strand  input  `STRANDS_PER_CORE  as the per-strand flush strobe.
REQ-012 The block SHALL have rb_rollback_pc  input  `STRANDS_PER_CORE*32  as the concatenated per-strand restart PCs.
REQ-013 The block SHALL have ss_instruction_req  input  `STRANDS_PER_CORE  as the per-strand head-consumed strobe from strand selection.
REQ-014 The block SHALL have if_instruction_valid  output  `STRANDS_PER_CORE  set when the strand buffer is non-empty.
REQ-015 The block SHALL have if_instruction  output  `STRANDS_PER_CORE*32  as the head instruction per strand.
REQ-016 The block SHALL have if_pc  output  `STRANDS_PER_CORE*32  as the head PC per strand.
REQ-017 The block SHALL have if_branch_predicted  output  `STRANDS_PER_CORE  as the head static prediction per strand.
REQ-018 The block SHALL have if_long_latency  output  `STRANDS_PER_CORE  as the head long-latency class per strand.

Function
REQ-019 Each strand SHALL own a 2-entry FIFO of {pc, instruction}, a 32-bit fetch PC, and a pending flag.
REQ-020 A strand SHALL be eligible to fetch when enabled, not pending, no request is outstanding core-wide, and FIFO count < 2.
REQ-021 A round-robin arbiter SHALL pick one eligible strand per cycle, starting the search after the last granted strand (strand 0 first after reset).
REQ-022 On grant, ifetch_request/ifetch_pc/ifetch_strand SHALL be driven combinationally that cycle; the strand's fetch PC SHALL advance by 4 and its pending flag SHALL set.
REQ-023 At most one request SHALL be outstanding core-wide; response latency is unbounded, minimum one cycle after the request.
REQ-024 On icache_data_valid, the word SHALL be pushed into icache_strand's FIFO with PC = fetch PC - 4 (captured at request), and pending SHALL clear.
REQ-025 Push and pop on the same strand in the same cycle SHALL both take effect; the count SHALL be unchanged.
REQ-026 ss_instruction_req[s] while if_instruction_valid[s]=0 SHALL be ignored.
REQ-027 An empty strand SHALL drive if_instruction = `NOP, if_pc = 0, and if_branch_predicted = if_long_latency = 0.
REQ-028 if_long_latency SHALL be 1 when head instruction[31:28] == 4'b1100.
REQ-029 if_branch_predicted SHALL be 1 when head instruction[31:28] == 4'b1111 and instruction[24] == 1.
REQ-030 rb_rollback_strand[s] SHALL empty FIFO s and load fetch PC s from rb_rollback_pc[s*32+:32] at the next edge.
REQ-031 If a request for strand s is outstanding at rollback, its response SHALL be discarded and pending SHALL clear when it arrives.
REQ-032 A response arriving in the same cycle as rollback of its strand SHALL be discarded.
REQ-033 Rollback SHALL take priority over a same-cycle pop or push.
REQ-034 A disabled strand SHALL keep its buffered entries visible but SHALL issue no new fetches.

Reset
REQ-035 While reset_n=0: all FIFOs empty, all fetch PCs = RESET_PC, all pending flags 0, arbiter pointer 0, ifetch_request=0, if_instruction_valid=0.

Verification
REQ-036 Reset release with enable=4'b0001 -> request PC 0 on strand 0; response 32'h1234_5678 -> if_pc[0]=0, valid[0]=1 the next cycle.
REQ-037 Strand 0 with no ss_instruction_req -> fetches at PC 0 and 4, then no request while count=2; single pop -> request PC 8.
REQ-038 All four strands enabled -> grants in order 0,1,2,3,0 with one outstanding request at a time.
REQ-039 Rollback strand 1 with PC 32'h100 while its request is outstanding -> late response dropped, valid[1]=0, next request PC 32'h100.
REQ-040 Head word 32'hF100_0000 -> if_branch_predicted=1; head word 32'hC000_0000 -> if_long_latency=1.
REQ-041 reset_n asserted mid-response -> all outputs return to reset values immediately, with no push.
